swap_decode_regbank: RTL and testbench

- Memory-subsystem utility block built from three primitives: a 2-way swap crossbar (cmux2), a 2-to-4 one-hot decoder (dec2) and an enabled, resettable register (flopenr).
- Used for I/D cache swapping (swc) and pointer-indexed 4-entry buffers with valid flags, as in the write buffer.
- Exposes the crossbar, the decoders and a 4-entry data/valid register bank.

---
 rtl/swap_decode_regbank.sv | 116 +++++++++++
 tb/tb_swap_decode_regbank.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/swap_decode_regbank.sv
`default_nettype none
// ============================================================================
// Module   : swap_decode_regbank
// Brief    : 2-way swap crossbar, 2-to-4 decoders and a 4-entry data/valid
//            register bank built from enabled, async-reset registers.
// Revision : 1.0 - initial release
// ============================================================================

module swap_decode_regbank_flopenr #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_q <= '0;
    else if (i_en) r_q <= i_d;
  end

  assign o_q = r_q;
endmodule

module swap_decode_regbank_dec2 (
  input  logic [1:0] i_sel,
  output logic [3:0] o_onehot
);
  assign o_onehot = 4'b0001 << i_sel;
endmodule

module swap_decode_regbank_cmux2 #(
  parameter int WIDTH = 32
) (
  input  logic             i_swap,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_y0,
  output logic [WIDTH-1:0] o_y1
);
  assign o_y0 = i_swap ? i_b : i_a;
  assign o_y1 = i_swap ? i_a : i_b;
endmodule

module swap_decode_regbank #(
  parameter int WIDTH = 32
) (
  input  logic             ph1,
  input  logic             reset,
  input  logic             swc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  input  logic             wr,
  input  logic [1:0]       wptr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd,
  input  logic [1:0]       rptr,
  output logic [3:0]       wsel,
  output logic [3:0]       rsel,
  output logic [WIDTH-1:0] rdata,
  output logic             rvalid,
  output logic [3:0]       valid
);
  logic [WIDTH-1:0] w_data [4];
  logic [3:0]       w_valid;
  logic [3:0]       w_wsel;
  logic [3:0]       w_rsel;

  swap_decode_regbank_cmux2 #(.WIDTH(WIDTH)) u_cmux2 (
    .i_swap (swc),
    .i_a    (a),
    .i_b    (b),
    .o_y0   (y0),
    .o_y1   (y1)
  );

  swap_decode_regbank_dec2 u_wdec (.i_sel(wptr), .o_onehot(w_wsel));
  swap_decode_regbank_dec2 u_rdec (.i_sel(rptr), .o_onehot(w_rsel));

  // Valid D is the write term alone, so a same-entry write/release keeps valid set.
  for (genvar i = 0; i < 4; i++) begin : g_entry
    logic w_wen;
    logic w_ven;
    assign w_wen = wr & w_wsel[i];
    assign w_ven = w_wen | (rd & w_rsel[i]);

    swap_decode_regbank_flopenr #(.WIDTH(WIDTH)) u_data (
      .clk   (ph1),
      .rst_n (reset),
      .i_en  (w_wen),
      .i_d   (wdata),
      .o_q   (w_data[i])
    );

    swap_decode_regbank_flopenr #(.WIDTH(1)) u_valid (
      .clk   (ph1),
      .rst_n (reset),
      .i_en  (w_ven),
      .i_d   (w_wen),
      .o_q   (w_valid[i])
    );
  end

  assign wsel   = w_wsel;
  assign rsel   = w_rsel;
  assign valid  = w_valid;
  assign rdata  = w_data[rptr];
  assign rvalid = w_valid[rptr];
endmodule

`default_nettype wire

// File: tb/tb_swap_decode_regbank.sv
`default_nettype none
// ============================================================================
// Module   : tb_swap_decode_regbank
// Brief    : Directed scoreboard bench for swap_decode_regbank.
// Revision : 1.0 - initial release
// ============================================================================
module tb_swap_decode_regbank;
  logic        ph1 = 1'b0;
  logic        reset, swc, wr, rd;
  logic [31:0] a, b, wdata;
  logic [1:0]  wptr, rptr;
  logic [31:0] y0, y1, rdata;
  logic [3:0]  wsel, rsel, valid;
  logic        rvalid;

  swap_decode_regbank #(.WIDTH(32)) dut (
    .ph1(ph1), .reset(reset), .swc(swc), .a(a), .b(b), .y0(y0), .y1(y1),
    .wr(wr), .wptr(wptr), .wdata(wdata), .rd(rd), .rptr(rptr),
    .wsel(wsel), .rsel(rsel), .rdata(rdata), .rvalid(rvalid), .valid(valid)
  );

  always #5 ph1 = ~ph1;

  typedef enum logic [2:0] {F_Y0, F_Y1, F_WSEL, F_RSEL, F_RDATA, F_RVALID, F_VALID} field_t;
  typedef struct {
    string       name;
    field_t      field;
    logic [31:0] exp;
  } item_t;

  item_t q[$];
  event  ev_check;
  int    n_tests = 0;
  int    n_fail  = 0;

  function automatic logic [31:0] actual(field_t f);
    case (f)
      F_Y0:     return y0;
      F_Y1:     return y1;
      F_WSEL:   return {28'd0, wsel};
      F_RSEL:   return {28'd0, rsel};
      F_RDATA:  return rdata;
      F_RVALID: return {31'd0, rvalid};
      default:  return {28'd0, valid};
    endcase
  endfunction

  // Monitor: drains the expectation queue each time the stimulus marks outputs as settled.
  initial begin
    item_t       it;
    logic [31:0] act;
    forever begin
      @(ev_check);
      while (q.size() > 0) begin
        it  = q.pop_front();
        act = actual(it.field);
        n_tests++;
        if (act !== it.exp) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
        end
      end
    end
  end

  task automatic exp_push(input string name, input field_t f, input logic [31:0] v);
    item_t it;
    it.name = name; it.field = f; it.exp = v;
    q.push_back(it);
  endtask

  task automatic check();
    #1;
    -> ev_check;
    #1;
  endtask

  task automatic tick();
    @(posedge ph1);
    #1;
  endtask

  task automatic write(input logic [1:0] p, input logic [31:0] d);
    wr = 1'b1; wptr = p; wdata = d;
    tick();
    wr = 1'b0;
  endtask

  task automatic read_chk(input string name, input logic [1:0] p,
                          input logic [31:0] d, input logic v);
    rptr = p;
    exp_push({name, "_rdata"}, F_RDATA, d);
    exp_push({name, "_rvalid"}, F_RVALID, {31'd0, v});
    check();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; swc = 1'b0; a = '0; b = '0;
    wr = 1'b1; wptr = 2'd2; wdata = 32'hDEADBEEF; rd = 1'b0; rptr = 2'd0;

    // Writes attempted during reset must be discarded.
    repeat (3) tick();
    exp_push("rst_valid", F_VALID, 32'h0);
    check();
    for (int i = 0; i < 4; i++) read_chk("rst_read", 2'(i), 32'h0, 1'b0);
    wr = 1'b0;
    reset = 1'b1;
    tick();
    exp_push("rst_rel_valid", F_VALID, 32'h0);
    read_chk("rst_rel_read2", 2'd2, 32'h0, 1'b0);

    a = 32'h11111111; b = 32'h22222222; swc = 1'b0;
    exp_push("xbar_s0_y0", F_Y0, 32'h11111111);
    exp_push("xbar_s0_y1", F_Y1, 32'h22222222);
    check();
    swc = 1'b1;
    exp_push("xbar_s1_y0", F_Y0, 32'h22222222);
    exp_push("xbar_s1_y1", F_Y1, 32'h11111111);
    check();
    for (int i = 0; i < 4; i++) begin
      wptr = 2'(i); rptr = 2'(3 - i);
      exp_push("wsel_sweep", F_WSEL, 32'd1 << i);
      exp_push("rsel_sweep", F_RSEL, 32'd1 << (3 - i));
      check();
    end

    tick();
    wr = 1'b1; wptr = 2'd1; wdata = 32'hCAFEF00D; rptr = 2'd1;
    read_chk("lat_pre", 2'd1, 32'h0, 1'b0);
    tick();
    wr = 1'b0;
    exp_push("lat_valid", F_VALID, 32'h2);
    read_chk("lat_post", 2'd1, 32'hCAFEF00D, 1'b1);

    for (int i = 0; i < 4; i++) write(2'(i), 32'hA0 + i);
    exp_push("fill_valid", F_VALID, 32'hF);
    check();
    for (int i = 0; i < 4; i++) read_chk("fill_read", 2'(i), 32'hA0 + i, 1'b1);
    rd = 1'b1; rptr = 2'd0;
    tick();
    rd = 1'b0;
    exp_push("rel0_valid", F_VALID, 32'hE);
    read_chk("rel0_read", 2'd0, 32'hA0, 1'b0);
    write(2'd0, 32'hB0);
    exp_push("wrap_valid", F_VALID, 32'hF);
    read_chk("wrap_read", 2'd0, 32'hB0, 1'b1);

    wr = 1'b1; wptr = 2'd2; wdata = 32'hC2; rd = 1'b1; rptr = 2'd2;
    tick();
    wr = 1'b0; rd = 1'b0;
    exp_push("coll_same_valid", F_VALID, 32'hF);
    read_chk("coll_same_read", 2'd2, 32'hC2, 1'b1);

    wr = 1'b1; wptr = 2'd3; wdata = 32'hD3; rd = 1'b1; rptr = 2'd1;
    tick();
    wr = 1'b0; rd = 1'b0;
    exp_push("coll_diff_valid", F_VALID, 32'hD);
    read_chk("coll_diff_read3", 2'd3, 32'hD3, 1'b1);

    rd = 1'b1; rptr = 2'd1;
    tick();
    rd = 1'b0;
    exp_push("rel_invalid_valid", F_VALID, 32'hD);
    check();
    write(2'd3, 32'hE3);
    exp_push("overwrite_valid", F_VALID, 32'hD);
    read_chk("overwrite_read", 2'd3, 32'hE3, 1'b1);

    write(2'd1, 32'hF1);
    exp_push("pre_async_valid", F_VALID, 32'hF);
    read_chk("pre_async_read", 2'd1, 32'hF1, 1'b1);
    reset = 1'b0;
    swc = 1'b0;
    exp_push("async_valid", F_VALID, 32'h0);
    exp_push("async_y0", F_Y0, 32'h11111111);
    read_chk("async_read", 2'd1, 32'h0, 1'b0);
    reset = 1'b1;
    tick();
    exp_push("post_async_valid", F_VALID, 32'h0);
    check();

    #2;
    if (q.size() != 0) begin
      n_fail += q.size();
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
